// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared MSHR entry types for the non-blocking data cache
// Purpose: entry state enum and entry record used by nbdcache_mshr_file.
// Ports: none (package).
package std_cache_pkg;

  // Line addresses are stored zero-extended to a fixed width so the record
  // does not depend on the instantiating module's AddrWidth.
  localparam int unsigned MshrLineWidth = 64;

  typedef enum logic [1:0] {
    MSHR_FREE     = 2'd0,
    MSHR_PENDING  = 2'd1,
    MSHR_INFLIGHT = 2'd2
  } mshr_state_e;

  typedef struct packed {
    mshr_state_e                state;
    logic [MshrLineWidth-1:0]   line_addr;
    logic                       we;
  } mshr_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small synchronous FIFO used as the MSHR issue-order queue
// Purpose: first-in first-out storage of DataWidth-bit words, Depth entries.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_i, data_i      write request and data (ignored when full)
//   pop_i, data_o       read request and head data (ignored when empty)
//   empty_o, full_o     occupancy flags
module fifo_v3 #(
  parameter int unsigned DataWidth = 2,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = PtrWidth + 1;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrWidth-1:0]  r_wr_ptr;
  logic [PtrWidth-1:0]  r_rd_ptr;
  logic [CntWidth-1:0]  r_count;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CntWidth'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through valid pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/nbdcache_mshr_file.sv
// rtl/nbdcache_mshr_file.sv - miss status holding register file for the non-blocking data cache
// Purpose: tracks outstanding line misses, arbitrates allocations round-robin,
//   issues refills in allocation order and frees entries on refill completion.
// Configuration: define NBDCACHE_MSHR_PERF_EN to build the allocation stall counter.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   alloc_valid_i/addr_i/we_i             per-port miss requests
//   alloc_ready_o, alloc_id_o             one-hot grant and granted entry id
//   issue_valid_o/ready_i/addr_o/id_o/we_o refill-engine handshake (line aligned)
//   done_valid_i, done_id_i               refill complete for an in-flight entry
//   lookup_addr_i, addr_match_o, index_match_o  per-port hazard lookups
//   flush_i, flush_ack_o                  drain request and one-shot acknowledge
//   busy_o, full_o, count_o, stall_cnt_o  status
module nbdcache_mshr_file
  import std_cache_pkg::*;
#(
  parameter int unsigned NumPorts   = 3,
  parameter int unsigned NumMshr    = 4,
  parameter int unsigned AddrWidth  = 56,
  parameter int unsigned IndexWidth = 12,
  parameter int unsigned ByteOffset = 4,
  parameter int unsigned IdWidth    = $clog2(NumMshr)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumPorts-1:0]                alloc_valid_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] alloc_addr_i,
  input  logic [NumPorts-1:0]                alloc_we_i,
  output logic [NumPorts-1:0]                alloc_ready_o,
  output logic [IdWidth-1:0]                 alloc_id_o,
  output logic                               issue_valid_o,
  input  logic                               issue_ready_i,
  output logic [AddrWidth-1:0]               issue_addr_o,
  output logic [IdWidth-1:0]                 issue_id_o,
  output logic                               issue_we_o,
  input  logic                               done_valid_i,
  input  logic [IdWidth-1:0]                 done_id_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] lookup_addr_i,
  output logic [NumPorts-1:0]                addr_match_o,
  output logic [NumPorts-1:0]                index_match_o,
  input  logic                               flush_i,
  output logic                               flush_ack_o,
  output logic                               busy_o,
  output logic                               full_o,
  output logic [IdWidth:0]                   count_o,
  output logic [31:0]                        stall_cnt_o
);

  localparam int unsigned PortWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned IdxBits   = IndexWidth - ByteOffset;

  mshr_entry_t          r_entries      [NumMshr];
  mshr_entry_t          w_entries_next [NumMshr];
  logic [PortWidth-1:0] r_rr_ptr;
  logic                 r_flush_armed;

  logic [NumMshr-1:0]   w_free;
  logic                 w_any_free;
  logic [IdWidth-1:0]   w_free_id;
  logic [IdWidth:0]     w_count;
  logic [NumPorts-1:0]  w_conflict;
  logic [NumPorts-1:0]  w_eligible;
  logic [NumPorts-1:0]  w_grant;
  logic                 w_grant_any;
  logic [PortWidth-1:0] w_grant_port;
  logic [PortWidth-1:0] w_cand;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [IdWidth-1:0]   w_head_id;
  logic                 w_issue_fire;

  function automatic logic [MshrLineWidth-1:0] line_of(input logic [AddrWidth-1:0] a);
    return MshrLineWidth'(a >> ByteOffset);
  endfunction

  // Occupancy: free vector, lowest free id, number of busy entries.
  always_comb begin
    w_free    = '0;
    w_free_id = '0;
    w_count   = '0;
    for (int k = 0; k < NumMshr; k++) begin
      w_free[k] = (r_entries[k].state == MSHR_FREE);
      if (!w_free[k]) w_count = w_count + 1'b1;
    end
    for (int k = int'(NumMshr) - 1; k >= 0; k--) begin
      if (w_free[k]) w_free_id = IdWidth'(k);
    end
  end

  assign w_any_free = |w_free;
  assign full_o     = ~w_any_free;
  assign count_o    = w_count;
  assign busy_o     = |w_count;

  // Line-address hazards for allocation and for the external lookups.
  always_comb begin
    w_conflict    = '0;
    addr_match_o  = '0;
    index_match_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int k = 0; k < NumMshr; k++) begin
        if (!w_free[k]) begin
          if (r_entries[k].line_addr == line_of(alloc_addr_i[p]))  w_conflict[p]   = 1'b1;
          if (r_entries[k].line_addr == line_of(lookup_addr_i[p])) addr_match_o[p] = 1'b1;
          if (r_entries[k].line_addr[IdxBits-1:0] == lookup_addr_i[p][IndexWidth-1:ByteOffset])
            index_match_o[p] = 1'b1;
        end
      end
    end
  end

  // Freeness is judged on registered state, so an entry completing this cycle
  // only becomes allocatable on the following one.
  assign w_eligible = alloc_valid_i & ~w_conflict &
                      {NumPorts{w_any_free & ~flush_i & ~rst_i}};

  // Round-robin search starting at r_rr_ptr.
  always_comb begin
    w_grant      = '0;
    w_grant_any  = 1'b0;
    w_grant_port = '0;
    w_cand       = '0;
    for (int o = 0; o < NumPorts; o++) begin
      if (int'(r_rr_ptr) + o >= int'(NumPorts)) w_cand = PortWidth'(int'(r_rr_ptr) + o - int'(NumPorts));
      else                                       w_cand = PortWidth'(int'(r_rr_ptr) + o);
      if (!w_grant_any && w_eligible[w_cand]) begin
        w_grant_any  = 1'b1;
        w_grant_port = w_cand;
      end
    end
    w_grant[w_grant_port] = w_grant_any;
  end

  assign alloc_ready_o = w_grant;
  assign alloc_id_o    = w_free_id;

  fifo_v3 #(
    .DataWidth (IdWidth),
    .Depth     (NumMshr)
  ) u_order_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_grant_any & ~w_fifo_full),
    .data_i  (w_free_id),
    .pop_i   (w_issue_fire),
    .data_o  (w_head_id),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  // The queue head is always a PENDING entry, so no state check is needed here.
  assign issue_valid_o = ~w_fifo_empty;
  assign issue_id_o    = w_head_id;
  assign issue_we_o    = r_entries[w_head_id].we;
  assign issue_addr_o  = AddrWidth'({r_entries[w_head_id].line_addr, {ByteOffset{1'b0}}});
  assign w_issue_fire  = issue_valid_o & issue_ready_i;

  // Per-entry state transitions; alloc, issue and done always target entries in
  // different states, so all three can take effect in the same cycle.
  always_comb begin
    w_entries_next = r_entries;
    for (int k = 0; k < NumMshr; k++) begin
      case (r_entries[k].state)
        MSHR_FREE: begin
          if (w_grant_any && w_free_id == IdWidth'(k)) begin
            w_entries_next[k].state     = MSHR_PENDING;
            w_entries_next[k].line_addr = line_of(alloc_addr_i[w_grant_port]);
            w_entries_next[k].we        = alloc_we_i[w_grant_port];
          end
        end
        MSHR_PENDING: begin
          if (w_issue_fire && w_head_id == IdWidth'(k)) w_entries_next[k].state = MSHR_INFLIGHT;
        end
        MSHR_INFLIGHT: begin
          if (done_valid_i && done_id_i == IdWidth'(k)) w_entries_next[k].state = MSHR_FREE;
        end
        default: w_entries_next[k].state = MSHR_FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumMshr; k++) begin
        r_entries[k] <= '{state: MSHR_FREE, line_addr: '0, we: 1'b0};
      end
    end else begin
      r_entries <= w_entries_next;
    end
  end

  // Flush acknowledge fires once per flush_i assertion, when the file is empty.
  assign flush_ack_o = flush_i & r_flush_armed & (w_count == '0) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr      <= '0;
      r_flush_armed <= 1'b1;
    end else begin
      if (w_grant_any) begin
        r_rr_ptr <= (w_grant_port == PortWidth'(NumPorts - 1)) ? '0 : w_grant_port + 1'b1;
      end
      if (!flush_i)         r_flush_armed <= 1'b1;
      else if (flush_ack_o) r_flush_armed <= 1'b0;
    end
  end

`ifdef NBDCACHE_MSHR_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if ((|alloc_valid_i) && full_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_nbdcache_mshr_file.sv
// tb/tb_nbdcache_mshr_file.sv - self-checking bench for nbdcache_mshr_file
module tb_nbdcache_mshr_file;

  localparam int NP = 3;
  localparam int NM = 4;

  logic             clk;
  logic             rst;
  logic [2:0]       alloc_valid;
  logic [2:0][55:0] alloc_addr;
  logic [2:0]       alloc_we;
  logic [2:0]       alloc_ready;
  logic [1:0]       alloc_id;
  logic             issue_valid;
  logic             issue_ready;
  logic [55:0]      issue_addr;
  logic [1:0]       issue_id;
  logic             issue_we;
  logic             done_valid;
  logic [1:0]       done_id;
  logic [2:0][55:0] lookup_addr;
  logic [2:0]       addr_match;
  logic [2:0]       index_match;
  logic             flush;
  logic             flush_ack;
  logic             busy;
  logic             full;
  logic [2:0]       count;
  logic [31:0]      stall_cnt;

  nbdcache_mshr_file dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .alloc_we_i    (alloc_we),
    .alloc_ready_o (alloc_ready),
    .alloc_id_o    (alloc_id),
    .issue_valid_o (issue_valid),
    .issue_ready_i (issue_ready),
    .issue_addr_o  (issue_addr),
    .issue_id_o    (issue_id),
    .issue_we_o    (issue_we),
    .done_valid_i  (done_valid),
    .done_id_i     (done_id),
    .lookup_addr_i (lookup_addr),
    .addr_match_o  (addr_match),
    .index_match_o (index_match),
    .flush_i       (flush),
    .flush_ack_o   (flush_ack),
    .busy_o        (busy),
    .full_o        (full),
    .count_o       (count),
    .stall_cnt_o   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: set of occupied entries, which of them were sent to the
  // refill engine, their line-aligned addresses, and the allocation order.
  bit          m_used [NM];
  bit          m_sent [NM];
  logic [55:0] m_addr [NM];
  bit          m_we   [NM];
  int          m_q[$];
  int          m_rr;
  bit          m_armed;
  longint      m_stall;

  int e_free;
  int e_grant;
  bit e_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] align(input logic [55:0] x);
    return (x >> 4) << 4;
  endfunction

  function automatic bit hit(input logic [55:0] x);
    for (int k = 0; k < NM; k++) if (m_used[k] && m_addr[k] == align(x)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit idx_hit(input logic [55:0] x);
    for (int k = 0; k < NM; k++)
      if (m_used[k] && ((m_addr[k] % 4096) / 16) == ((x % 4096) / 16)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NM; k++) begin
      m_used[k] = 0; m_sent[k] = 0; m_addr[k] = '0; m_we[k] = 0;
    end
    m_q.delete();
    m_rr = 0;
    m_armed = 1;
    m_stall = 0;
  endtask

  task automatic clr_inputs();
    alloc_valid = '0; alloc_addr = '0; alloc_we = '0;
    issue_ready = 0; done_valid = 0; done_id = '0;
    lookup_addr = '0; flush = 0;
  endtask

  // Settle, predict every output from the model and compare.
  task automatic eval();
    int cnt;
    logic [2:0] e_ready, e_am, e_im;
    #1;
    e_free = -1;
    cnt = 0;
    for (int k = NM - 1; k >= 0; k--) if (!m_used[k]) e_free = k;
    for (int k = 0; k < NM; k++) if (m_used[k]) cnt++;
    e_grant = -1;
    if (!rst && e_free >= 0 && !flush) begin
      for (int o = 0; o < NP; o++) begin
        int p;
        p = (m_rr + o) % NP;
        if (e_grant < 0 && alloc_valid[p] && !hit(alloc_addr[p])) e_grant = p;
      end
    end
    e_ready = (e_grant >= 0) ? 3'(1 << e_grant) : 3'b000;
    for (int p = 0; p < NP; p++) begin
      e_am[p] = hit(lookup_addr[p]);
      e_im[p] = idx_hit(lookup_addr[p]);
    end
    e_ack = flush && !rst && cnt == 0 && m_armed;
    check("alloc_ready", alloc_ready, e_ready);
    if (e_grant >= 0) check("alloc_id", alloc_id, e_free);
    check("issue_valid", issue_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("issue_addr", issue_addr, m_addr[m_q[0]]);
      check("issue_id", issue_id, m_q[0]);
      check("issue_we", issue_we, m_we[m_q[0]]);
    end
    check("addr_match", addr_match, e_am);
    check("index_match", index_match, e_im);
    check("full", full, e_free < 0);
    check("count", count, cnt);
    check("busy", busy, cnt != 0);
    check("flush_ack", flush_ack, e_ack);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  // Apply the cycle's effects to the model, then cross the clock edge.
  task automatic advance();
    bit dn;
    int h;
    if (rst) begin
      model_reset();
    end else begin
      dn = done_valid && m_used[done_id] && m_sent[done_id];
`ifdef NBDCACHE_MSHR_PERF_EN
      if ((alloc_valid != 0) && e_free < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
      if (m_q.size() != 0 && issue_ready) begin
        h = m_q.pop_front();
        m_sent[h] = 1;
      end
      if (dn) begin
        m_used[done_id] = 0;
        m_sent[done_id] = 0;
      end
      if (e_grant >= 0) begin
        m_used[e_free] = 1;
        m_sent[e_free] = 0;
        m_addr[e_free] = align(alloc_addr[e_grant]);
        m_we[e_free]   = alloc_we[e_grant];
        m_q.push_back(e_free);
        m_rr = (e_grant + 1) % NP;
      end
      if (!flush) m_armed = 1;
      else if (e_ack) m_armed = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    clr_inputs();
    alloc_valid = 3'b111;
    flush = 1;
    eval();
    check("rst_ready", alloc_ready, 0);
    check("rst_ack", flush_ack, 0);
    check("rst_count", count, 0);
    advance();
    advance();
    rst = 0;
    clr_inputs();
  endtask

  function automatic logic [55:0] rand_addr();
    return (56'($urandom_range(0, 1)) << 40) | (56'($urandom_range(0, 3)) << 12) |
           (56'($urandom_range(0, 3)) << 4) | 56'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1;
    clr_inputs();
    model_reset();

    // Single allocation on port 1 and its issue.
    do_reset();
    alloc_valid = 3'b010; alloc_addr[1] = 56'h1000; alloc_we[1] = 1;
    eval();
    check("r25_ready", alloc_ready, 3'b010);
    check("r25_id", alloc_id, 0);
    advance();
    alloc_valid = 0;
    eval();
    check("r25_ivalid", issue_valid, 1);
    check("r25_iaddr", issue_addr, 56'h1000);
    check("r25_iid", issue_id, 0);
    advance();

    // Round-robin over three held requests, then issue order.
    do_reset();
    alloc_valid = 3'b111;
    alloc_addr[0] = 56'h100; alloc_addr[1] = 56'h200; alloc_addr[2] = 56'h300;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("r26_ready", alloc_ready, 64'd1 << i);
      check("r26_id", alloc_id, i);
      advance();
    end
    eval();
    check("r26_no_regrant", alloc_ready, 0);
    advance();
    alloc_valid = 0; issue_ready = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      check("r26_issue_addr", issue_addr, (i + 1) * 256);
      advance();
    end
    issue_ready = 0;

    // Full file, then a freed entry becomes allocatable one cycle later.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 3'b001; alloc_addr[0] = 56'((i + 1) << 12);
      eval();
      check("r27_fill_id", alloc_id, i);
      advance();
    end
    alloc_valid = 3'b010; alloc_addr[1] = 56'h5000; issue_ready = 1;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("r27_full", full, 1);
      check("r27_blocked", alloc_ready, 0);
      advance();
    end
    issue_ready = 0;
    eval();
    advance();
    done_valid = 1; done_id = 2;
    eval();
    check("r27_no_grant_t", alloc_ready, 0);
    advance();
    done_valid = 0;
    eval();
    check("r27_grant_t1", alloc_ready, 3'b010);
    check("r27_id_t1", alloc_id, 2);
`ifdef NBDCACHE_MSHR_PERF_EN
    check("r27_stall", stall_cnt, 6);
`else
    check("r27_stall", stall_cnt, 0);
`endif
    advance();

    // Same-line block and lookup compares.
    do_reset();
    alloc_valid = 3'b001; alloc_addr[0] = 56'h2040;
    eval();
    check("r28_first", alloc_ready, 3'b001);
    advance();
    alloc_addr[0] = 56'h2048; lookup_addr[0] = 56'h2044; lookup_addr[1] = 56'h3040;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("r28_same_line", alloc_ready, 0);
      advance();
    end
    eval();
    check("r28_addr_match0", addr_match[0], 1);
    check("r28_index_match1", index_match[1], 1);
    check("r28_addr_match1", addr_match[1], 0);
    advance();

    // Flush blocks allocation and acknowledges once when drained.
    do_reset();
    alloc_valid = 3'b001; alloc_addr[0] = 56'h600;
    eval(); advance();
    alloc_addr[0] = 56'h700;
    eval(); advance();
    alloc_valid = 0; issue_ready = 1;
    eval(); advance();
    eval(); advance();
    issue_ready = 0; flush = 1; alloc_valid = 3'b001; alloc_addr[0] = 56'h500;
    eval();
    check("r29_flush_block", alloc_ready, 0);
    check("r29_no_ack_busy", flush_ack, 0);
    advance();
    done_valid = 1; done_id = 0;
    eval(); advance();
    done_id = 1;
    eval(); advance();
    done_valid = 0;
    eval();
    check("r29_ack", flush_ack, 1);
    check("r29_ack_grant", alloc_ready, 0);
    advance();
    eval();
    check("r29_no_second", flush_ack, 0);
    advance();
    flush = 0;
    eval(); advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        alloc_addr[p]  = rand_addr();
        lookup_addr[p] = rand_addr();
      end
      alloc_valid = 3'($urandom);
      alloc_we    = 3'($urandom);
      issue_ready = 1'($urandom);
      done_valid  = ($urandom % 3) != 0;
      done_id     = 2'($urandom);
      if ($urandom % 20 == 0) flush = ~flush;
      eval();
      advance();
    end

    // Reset in the middle of traffic discards everything.
    rst = 1;
    model_reset();
    eval();
    advance();
    rst = 0;
    clr_inputs();
    eval();
    check("r21_no_issue", issue_valid, 0);
    check("r21_count", count, 0);
    advance();
    eval();
    check("r21_no_issue_next", issue_valid, 0);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
